ram_fifo_ctrl: RTL and testbench

Synchronous FIFO controller that sits directly upstream of the 8x4 single-port RAM and drives its `data_in`/`wr`/`rd`/`add` inputs, while consuming its `data_out`. It turns a push/pop handshake into single-port RAM accesses, tracks circular read and write pointers, and reports occupancy. After every reset it clears all RAM locations before accepting traffic. One access per cycle reaches the RAM; simultaneous requests are arbitrated round-robin.

---
 rtl/ram_fifo_ctrl_if.sv | 37 +++
 rtl/ram_fifo_ctrl.sv | 134 +++++++++++++
 tb/tb_ram_fifo_ctrl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/ram_fifo_ctrl_if.sv
// Push/pop handshake, occupancy/status and RAM-port bundle for ram_fifo_ctrl.
// slave = the controller; master = the traffic source plus the RAM it drives.
interface ram_fifo_ctrl_if #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 3
);
  logic              push;
  logic [DATA_W-1:0] push_data;
  logic              push_ready;
  logic              pop;
  logic              pop_ready;
  logic [DATA_W-1:0] pop_data;
  logic              pop_valid;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              init_done;
  logic              overflow;
  logic              underflow;
  logic [DATA_W-1:0] ram_data_in;
  logic              ram_wr;
  logic              ram_rd;
  logic [ADDR_W-1:0] ram_add;
  logic [DATA_W-1:0] ram_data_out;

  modport slave (
    input  push, push_data, pop, ram_data_out,
    output push_ready, pop_ready, pop_data, pop_valid, full, empty, count,
           init_done, overflow, underflow, ram_data_in, ram_wr, ram_rd, ram_add
  );

  modport master (
    output push, push_data, pop, ram_data_out,
    input  push_ready, pop_ready, pop_data, pop_valid, full, empty, count,
           init_done, overflow, underflow, ram_data_in, ram_wr, ram_rd, ram_add
  );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller over a single-port RAM: clears the RAM after reset, then one push or pop per cycle, round-robin on contention.
// Pop data arrives one cycle after acceptance; sticky overflow/underflow flags exist only with RAM_FIFO_CTRL_ERR_FLAGS_EN.
module ram_fifo_ctrl #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 3
) (
  input  logic         clk,
  input  logic         rst,
  ram_fifo_ctrl_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(DEPTH - 1);

  typedef enum logic {INIT, RUN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              prio_q, prio_d;
  logic              pop_valid_q, pop_valid_d;

  logic              full, empty, push_req, pop_req;
  logic              push_rdy, pop_rdy, init_done;
  logic              ram_wr, ram_rd;
  logic [ADDR_W-1:0] ram_add;
  logic [DATA_W-1:0] ram_din;

  assign full     = (count_q == DEPTH_C);
  assign empty    = (count_q == '0);
  assign push_req = bus.push & ~full;
  assign pop_req  = bus.pop & ~empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= INIT;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      init_cnt_q  <= '0;
      count_q     <= '0;
      prio_q      <= 1'b0;
      pop_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      init_cnt_q  <= init_cnt_d;
      count_q     <= count_d;
      prio_q      <= prio_d;
      pop_valid_q <= pop_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    init_cnt_d  = init_cnt_q;
    count_d     = count_q;
    prio_d      = prio_q;
    pop_valid_d = 1'b0;
    push_rdy    = 1'b0;
    pop_rdy     = 1'b0;
    init_done   = 1'b0;
    ram_wr      = 1'b0;
    ram_rd      = 1'b0;
    ram_add     = rd_ptr_q;
    ram_din     = '0;
    case (state_q)
      INIT: begin
        ram_wr     = 1'b1;
        ram_add    = init_cnt_q;
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == LAST_C) state_d = RUN;
      end
      RUN: begin
        init_done = 1'b1;
        // prio=1 means pop wins the next contention; the loser must hold its request
        push_rdy  = ~full & (~pop_req | ~prio_q);
        pop_rdy   = ~empty & (~push_req | prio_q);
        if (bus.push & push_rdy) begin
          ram_wr   = 1'b1;
          ram_add  = wr_ptr_q;
          ram_din  = bus.push_data;
          wr_ptr_d = wr_ptr_q + 1'b1;
          count_d  = count_q + 1'b1;
          prio_d   = 1'b1;
        end else if (bus.pop & pop_rdy) begin
          ram_rd      = 1'b1;
          rd_ptr_d    = rd_ptr_q + 1'b1;
          count_d     = count_q - 1'b1;
          prio_d      = 1'b0;
          pop_valid_d = 1'b1;
        end
      end
      default: state_d = INIT;
    endcase
  end

  assign bus.push_ready  = push_rdy;
  assign bus.pop_ready   = pop_rdy;
  assign bus.init_done   = init_done;
  assign bus.full        = full;
  assign bus.empty       = empty;
  assign bus.count       = count_q;
  assign bus.pop_valid   = pop_valid_q;
  assign bus.pop_data    = bus.ram_data_out;
  assign bus.ram_wr      = ram_wr;
  assign bus.ram_rd      = ram_rd;
  assign bus.ram_add     = ram_add;
  assign bus.ram_data_in = ram_din;

`ifdef RAM_FIFO_CTRL_ERR_FLAGS_EN
  logic overflow_q, underflow_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (state_q == RUN) begin
      if (bus.push & full) overflow_q  <= 1'b1;
      if (bus.pop & empty) underflow_q <= 1'b1;
    end
  end

  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
`else
  assign bus.overflow  = 1'b0;
  assign bus.underflow = 1'b0;
`endif
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl: queue-based reference model checked every cycle, directed scenarios with literal expectations, then random traffic.
module tb_ram_fifo_ctrl;
  localparam int DW = 4;
  localparam int AW = 3;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ram_fifo_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus();
  ram_fifo_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  // 8x4 single-port RAM, data_out registered on a read edge
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] ram_q;
  always @(posedge clk) begin
    if (bus.ram_wr) mem[bus.ram_add] <= bus.ram_data_in;
    else if (bus.ram_rd) ram_q <= mem[bus.ram_add];
  end
  assign bus.ram_data_out = ram_q;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  bit m_known = 0;
  int m_init_left = DEPTH;
  int q[$];
  bit m_prio = 0;
  bit m_pv = 0;
  int m_pd = 0;
  bit m_ovf = 0;
  bit m_udf = 0;
  int m_wt = 0;
  int m_rt = 0;

  // last sampled DUT outputs, for directed literal checks
  logic [31:0] obs_add, obs_wr, obs_rd, obs_cnt, obs_pd, obs_pv, obs_idone;
  logic [31:0] obs_full, obs_empty, obs_prdy, obs_pordy, obs_ovf, obs_udf;

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    n_vec++;
    if (act !== 32'(exp)) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input bit r, input bit ps, input int d, input bit pp);
    bit in_init, fl, em, pr, por, pok, ook, e_wr, e_rd;
    int n, e_add, e_din;
    @(negedge clk);
    rst = r;
    bus.push = ps;
    bus.push_data = 4'(d);
    bus.pop = pp;
    #1;
    n = q.size();
    in_init = (m_init_left > 0);
    fl = (n == DEPTH);
    em = (n == 0);
    if (in_init) begin
      pr = 0; por = 0; pok = 0; ook = 0;
      e_wr = 1; e_rd = 0; e_add = DEPTH - m_init_left; e_din = 0;
    end else begin
      pr  = !fl && !(pp && !em && m_prio);
      por = !em && !(ps && !fl && !m_prio);
      pok = ps && pr;
      ook = pp && por;
      e_wr = pok;
      e_rd = ook;
      e_add = pok ? (m_wt % DEPTH) : (m_rt % DEPTH);
      e_din = pok ? d : 0;
    end
    obs_add = 32'(bus.ram_add);   obs_wr = 32'(bus.ram_wr);   obs_rd = 32'(bus.ram_rd);
    obs_cnt = 32'(bus.count);     obs_pd = 32'(bus.pop_data); obs_pv = 32'(bus.pop_valid);
    obs_idone = 32'(bus.init_done); obs_full = 32'(bus.full); obs_empty = 32'(bus.empty);
    obs_prdy = 32'(bus.push_ready); obs_pordy = 32'(bus.pop_ready);
    obs_ovf = 32'(bus.overflow);  obs_udf = 32'(bus.underflow);
    if (m_known) begin
      chk("push_ready", obs_prdy, int'(pr));
      chk("pop_ready", obs_pordy, int'(por));
      chk("init_done", obs_idone, int'(!in_init));
      chk("ram_wr", obs_wr, int'(e_wr));
      chk("ram_rd", obs_rd, int'(e_rd));
      chk("wr_rd_excl", obs_wr & obs_rd, 0);
      chk("ram_add", obs_add, e_add);
      chk("ram_data_in", 32'(bus.ram_data_in), e_din);
      chk("count", obs_cnt, n);
      chk("full", obs_full, int'(fl));
      chk("empty", obs_empty, int'(em));
      chk("pop_valid", obs_pv, int'(m_pv));
      if (m_pv) chk("pop_data", obs_pd, m_pd);
      chk("overflow", obs_ovf, int'(m_ovf));
      chk("underflow", obs_udf, int'(m_udf));
    end
    @(posedge clk);
    if (r) begin
      m_known = 1; m_init_left = DEPTH; q.delete();
      m_wt = 0; m_rt = 0; m_prio = 0; m_pv = 0; m_ovf = 0; m_udf = 0;
    end else if (in_init) begin
      m_init_left--;
      m_pv = 0;
    end else begin
      m_pv = ook;
      if (ook) begin m_pd = q.pop_front(); m_rt++; m_prio = 0; end
      if (pok) begin q.push_back(d); m_wt++; m_prio = 1; end
`ifdef RAM_FIFO_CTRL_ERR_FLAGS_EN
      if (ps && fl) m_ovf = 1;
      if (pp && em) m_udf = 1;
`endif
    end
  endtask

  int fillv[8] = '{10, 11, 12, 13, 14, 15, 1, 2};

  initial begin
    bus.push = 0; bus.push_data = '0; bus.pop = 0;
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);

    // RAM clear sequence
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 0, 0, 0);
      chk("init_add_lit", obs_add, i);
      chk("init_wr_lit", obs_wr, 1);
      chk("init_idone_lit", obs_idone, 0);
    end
    step(0, 0, 0, 0);
    chk("init_done_c9_lit", obs_idone, 1);
    chk("empty_after_init_lit", obs_empty, 1);

    // push 0..3 then pop 4
    for (int i = 0; i < 4; i++) step(0, 1, i, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, i < 4);
      if (i < 4) chk("pop_add_lit", obs_add, i);
      if (i > 0) chk("pop_data_lit", obs_pd, i - 1);
    end
    chk("empty_end_lit", obs_empty, 1);

    // fill to full, one extra push, drain
    for (int i = 0; i < 8; i++) step(0, 1, fillv[i], 0);
    step(0, 1, 7, 0);
    chk("full_lit", obs_full, 1);
    chk("count8_lit", obs_cnt, 8);
    chk("push_rdy_full_lit", obs_prdy, 0);
    for (int i = 0; i < 9; i++) begin
      step(0, 0, 0, i < 8);
      if (i > 0) chk("drain_data_lit", obs_pd, fillv[i - 1]);
    end
`ifdef RAM_FIFO_CTRL_ERR_FLAGS_EN
    chk("overflow_lit", obs_ovf, 1);
`else
    chk("overflow_tied_lit", obs_ovf, 0);
`endif

    // pointer wrap: move pointers to 6, then push/pop 4 across the 7->0 boundary
    for (int i = 0; i < 2; i++) step(0, 1, 3 + i, 0);
    for (int i = 0; i < 2; i++) step(0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 5 + i, 0);
      chk("wrap_wadd_lit", obs_add, (6 + i) % 8);
    end
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, i < 4);
      if (i < 4) chk("wrap_radd_lit", obs_add, (6 + i) % 8);
      if (i > 0) chk("wrap_data_lit", obs_pd, 5 + i - 1);
    end

    // contention with prio=1 and two entries
    step(0, 1, 9, 0);
    step(0, 1, 10, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 11 + i, 1);
      chk("cont_rd_lit", obs_rd, (i % 2 == 0) ? 1 : 0);
      chk("cont_wr_lit", obs_wr, (i % 2 == 1) ? 1 : 0);
    end
    step(0, 0, 0, 0);
    chk("cont_count_lit", obs_cnt, 2);

    // reset at count 5, pop held through the clear
    for (int i = 0; i < 3; i++) step(0, 1, i, 0);
    step(0, 0, 0, 0);
    chk("count5_lit", obs_cnt, 5);
    step(1, 0, 0, 0);
    step(0, 0, 0, 1);
    chk("rst_wr_lit", obs_wr, 1);
    chk("rst_add_lit", obs_add, 0);
    chk("rst_count_lit", obs_cnt, 0);
    chk("rst_pv_lit", obs_pv, 0);
    for (int i = 0; i < 7; i++) begin
      step(0, 0, 0, 1);
      chk("init_pop_rdy_lit", obs_pordy, 0);
    end
    step(0, 0, 0, 1);
    chk("run_empty_lit", obs_empty, 1);
    chk("run_pop_rdy_lit", obs_pordy, 0);
    step(0, 0, 0, 0);
`ifdef RAM_FIFO_CTRL_ERR_FLAGS_EN
    chk("underflow_lit", obs_udf, 1);
`else
    chk("underflow_tied_lit", obs_udf, 0);
`endif

    // random traffic with alternating bias so both full and empty are visited
    for (int i = 0; i < 800; i++) begin
      int bp;
      bit rr, ps, pp;
      bp = ((i / 100) % 2 == 1) ? 75 : 30;
      ps = ($urandom_range(99) < bp);
      pp = ($urandom_range(99) < (100 - bp));
      rr = ($urandom_range(299) == 0);
      step(rr, ps, int'($urandom_range(15)), pp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
